mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter (instruction fetch / data) sharing one CPU_MIO-style memory port.
// Data wins by default; a bounded data streak guarantees fetch progress, and a wait timeout aborts stuck transactions.
module mem_bus_arbiter #(
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_type,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [2:0]  bus_type,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready,
    output logic        bus_err,
    output logic [31:0] err_addr
);

    localparam int SW = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
    localparam logic [7:0]    WAIT_LAST  = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, GRANT_IF, GRANT_D} state_t;

    state_t        state, state_next;
    logic [SW-1:0] streak;
    logic [7:0]    wait_cnt;
    logic          grant_if, grant_d, done, abort;

    function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
        return (v == STREAK_MAX) ? v : v + 1'b1;
    endfunction

    assign bus_req = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        grant_if   = 1'b0;
        grant_d    = 1'b0;
        done       = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && (!if_req || streak < STREAK_MAX)) begin
                    grant_d    = 1'b1;
                    state_next = GRANT_D;
                end else if (if_req) begin
                    grant_if   = 1'b1;
                    state_next = GRANT_IF;
                end
            end
            GRANT_IF, GRANT_D: begin
                // A ready response on the final wait edge still counts as a real completion.
                if (bus_ready) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            streak    <= '0;
            wait_cnt  <= 8'd0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'h0;
            bus_wdata <= 32'h0;
            bus_type  <= 3'd0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            if_rdata  <= 32'h0;
            d_rdata   <= 32'h0;
            bus_err   <= 1'b0;
            err_addr  <= 32'h0;
        end else begin
            if_ack  <= 1'b0;
            d_ack   <= 1'b0;
            bus_err <= 1'b0;
            if (grant_d) begin
                bus_we    <= d_we;
                bus_addr  <= d_addr;
                bus_wdata <= d_wdata;
                bus_type  <= d_type;
                wait_cnt  <= 8'd0;
                streak    <= if_req ? sat_inc(streak) : '0;
            end
            if (grant_if) begin
                bus_we    <= 1'b0;
                bus_addr  <= if_addr;
                bus_wdata <= 32'h0;
                bus_type  <= 3'd0;
                wait_cnt  <= 8'd0;
                streak    <= '0;
            end
            if (bus_req && !bus_ready) wait_cnt <= wait_cnt + 8'd1;
            // Aborted reads return zero data; writes never touch d_rdata.
            if (done || abort) begin
                if (state == GRANT_IF) begin
                    if_ack   <= 1'b1;
                    if_rdata <= done ? bus_rdata : 32'h0;
                end else begin
                    d_ack <= 1'b1;
                    if (!bus_we) d_rdata <= done ? bus_rdata : 32'h0;
                end
            end
            if (abort) begin
                bus_err  <= 1'b1;
                err_addr <= bus_addr;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_mem_bus_arbiter;

    localparam int MAX = 4;
    localparam int TO  = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_we, bus_ready;
    logic [31:0] if_addr, d_addr, d_wdata, bus_rdata;
    logic [2:0]  d_type;
    logic [31:0] if_rdata, d_rdata, bus_addr, bus_wdata, err_addr;
    logic        if_ack, d_ack, bus_req, bus_we, bus_err;
    logic [2:0]  bus_type;

    int n_vec = 0;
    int n_bad = 0;

    mem_bus_arbiter #(.MAX_D_STREAK(MAX), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_type(d_type),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_type(bus_type), .bus_rdata(bus_rdata), .bus_ready(bus_ready),
        .bus_err(bus_err), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: one outstanding transaction, described by its owner and fields.
    int          m_owner;  // 0 none, 1 fetch, 2 data
    int          m_wait, m_streak;
    logic        m_we, m_if_ack, m_d_ack, m_err;
    logic [31:0] m_addr, m_wdata, m_if_rdata, m_d_rdata, m_err_addr;
    logic [2:0]  m_type;

    function automatic void m_reset();
        m_owner = 0; m_wait = 0; m_streak = 0;
        m_we = 1'b0; m_addr = 32'h0; m_wdata = 32'h0; m_type = 3'd0;
        m_if_ack = 1'b0; m_d_ack = 1'b0; m_err = 1'b0;
        m_if_rdata = 32'h0; m_d_rdata = 32'h0; m_err_addr = 32'h0;
    endfunction

    function automatic void m_edge();
        m_if_ack = 1'b0; m_d_ack = 1'b0; m_err = 1'b0;
        if (m_owner == 0) begin
            if (d_req && (!if_req || m_streak < MAX)) begin
                m_owner = 2; m_wait = 0;
                m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; m_type = d_type;
                m_streak = if_req ? ((m_streak < MAX) ? m_streak + 1 : MAX) : 0;
            end else if (if_req) begin
                m_owner = 1; m_wait = 0; m_streak = 0;
                m_we = 1'b0; m_addr = if_addr; m_wdata = 32'h0; m_type = 3'd0;
            end
        end else begin
            bit fin;
            bit tmo;
            fin = bus_ready;
            tmo = 1'b0;
            if (!fin) begin
                m_wait++;
                tmo = (m_wait >= TO);
            end
            if (fin || tmo) begin
                if (m_owner == 1) begin
                    m_if_ack = 1'b1;
                    m_if_rdata = fin ? bus_rdata : 32'h0;
                end else begin
                    m_d_ack = 1'b1;
                    if (!m_we) m_d_rdata = fin ? bus_rdata : 32'h0;
                end
                if (tmo) begin
                    m_err = 1'b1;
                    m_err_addr = m_addr;
                end
                m_owner = 0;
            end
        end
    endfunction

    task automatic clear_inputs();
        if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
        d_addr = 32'h0; d_wdata = 32'h0; d_type = 3'd0;
        bus_ready = 1'b0; bus_rdata = 32'h0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_inputs();
        repeat (2) tick();
        reset = 1'b1;
        m_reset();
    endtask

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req, d_we;
        logic [31:0] d_addr, d_wdata;
        logic [2:0]  d_type;
        logic        rdy;
        logic [31:0] rdata;
        logic        e_req, e_we;
        logic [31:0] e_addr, e_wdata;
        logic [2:0]  e_type;
        logic        e_if_ack, e_d_ack;
        logic [31:0] e_if_rdata, e_d_rdata;
    } vec_t;

    vec_t        tbl[10];
    logic [31:0] grants[10];
    int          ng, cnt;

    initial begin
        tbl[0] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 32'h0,
                   1'b1, 1'b0, 32'h100, 32'h0, 3'd0, 1'b0, 1'b0, 32'h0, 32'h0};
        tbl[1] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 32'h00500093,
                   1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 1'b0, 32'h00500093, 32'h0};
        tbl[2] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 32'h0,
                   1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 32'h00500093, 32'h0};
        tbl[3] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h2000, 32'hCAFEF00D, 3'd0, 1'b0, 32'h0,
                   1'b1, 1'b1, 32'h2000, 32'hCAFEF00D, 3'd0, 1'b0, 1'b0, 32'h00500093, 32'h0};
        tbl[4] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h9999, 32'h1111, 3'd7, 1'b0, 32'hDEAD,
                   1'b1, 1'b1, 32'h2000, 32'hCAFEF00D, 3'd0, 1'b0, 1'b0, 32'h00500093, 32'h0};
        tbl[5] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h9999, 32'h1111, 3'd7, 1'b1, 32'h12345678,
                   1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b1, 32'h00500093, 32'h0};
        tbl[6] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h44, 32'hCAFEF00D, 3'd2, 1'b1, 32'hAAAA,
                   1'b1, 1'b0, 32'h44, 32'hCAFEF00D, 3'd2, 1'b0, 1'b0, 32'h00500093, 32'h0};
        tbl[7] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h44, 32'hCAFEF00D, 3'd2, 1'b1, 32'h55AA55AA,
                   1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b1, 32'h00500093, 32'h55AA55AA};
        tbl[8] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h48, 32'h0, 3'd2, 1'b0, 32'h0,
                   1'b1, 1'b0, 32'h48, 32'h0, 3'd2, 1'b0, 1'b0, 32'h00500093, 32'h55AA55AA};
        tbl[9] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h48, 32'h0, 3'd2, 1'b1, 32'h11,
                   1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b1, 32'h00500093, 32'h11};

        reset = 1'b0;
        clear_inputs();
        #1;
        check1("rst_bus_req", bus_req, 1'b0);
        tick();
        check1("rst_bus_we", bus_we, 1'b0);
        check32("rst_bus_addr", bus_addr, 32'h0);
        check32("rst_bus_wdata", bus_wdata, 32'h0);
        check32("rst_bus_type", {29'b0, bus_type}, 32'h0);
        check1("rst_if_ack", if_ack, 1'b0);
        check1("rst_d_ack", d_ack, 1'b0);
        check1("rst_bus_err", bus_err, 1'b0);
        check32("rst_if_rdata", if_rdata, 32'h0);
        check32("rst_d_rdata", d_rdata, 32'h0);
        check32("rst_err_addr", err_addr, 32'h0);
        do_reset();

        // Directed table: single fetch, data write, data reads, back-to-back request.
        for (int i = 0; i < 10; i++) begin
            if_req = tbl[i].if_req; if_addr = tbl[i].if_addr;
            d_req = tbl[i].d_req; d_we = tbl[i].d_we; d_addr = tbl[i].d_addr;
            d_wdata = tbl[i].d_wdata; d_type = tbl[i].d_type;
            bus_ready = tbl[i].rdy; bus_rdata = tbl[i].rdata;
            tick();
            check1($sformatf("tbl%0d_bus_req", i), bus_req, tbl[i].e_req);
            if (tbl[i].e_req) begin
                check1($sformatf("tbl%0d_bus_we", i), bus_we, tbl[i].e_we);
                check32($sformatf("tbl%0d_bus_addr", i), bus_addr, tbl[i].e_addr);
                check32($sformatf("tbl%0d_bus_wdata", i), bus_wdata, tbl[i].e_wdata);
                check32($sformatf("tbl%0d_bus_type", i), {29'b0, bus_type}, {29'b0, tbl[i].e_type});
            end
            check1($sformatf("tbl%0d_if_ack", i), if_ack, tbl[i].e_if_ack);
            check1($sformatf("tbl%0d_d_ack", i), d_ack, tbl[i].e_d_ack);
            check32($sformatf("tbl%0d_if_rdata", i), if_rdata, tbl[i].e_if_rdata);
            check32($sformatf("tbl%0d_d_rdata", i), d_rdata, tbl[i].e_d_rdata);
            check1($sformatf("tbl%0d_bus_err", i), bus_err, 1'b0);
        end

        // Contention: both requesters held high, memory always ready.
        do_reset();
        if_req = 1'b1; if_addr = 32'h100;
        d_req = 1'b1; d_addr = 32'h200; bus_ready = 1'b1;
        ng = 0;
        for (int c = 0; c < 40 && ng < 10; c++) begin
            tick();
            if (bus_req) begin
                grants[ng] = bus_addr;
                ng++;
            end
        end
        check32("contention_grant_count", ng, 10);
        for (int i = 0; i < ng; i++)
            check32($sformatf("contention_grant%0d", i), grants[i], (i % 5 == 4) ? 32'h100 : 32'h200);

        // Timeout after a successful read so the zeroed d_rdata is observable.
        do_reset();
        d_req = 1'b1; d_addr = 32'h10;
        tick();
        d_req = 1'b0; bus_ready = 1'b1; bus_rdata = 32'h77;
        tick();
        check32("pre_timeout_d_rdata", d_rdata, 32'h77);
        bus_ready = 1'b0; d_req = 1'b1; d_addr = 32'h3000;
        tick();
        d_req = 1'b0;
        cnt = 0;
        while (bus_req === 1'b1 && cnt < 400) begin
            cnt++;
            tick();
        end
        check32("timeout_grant_cycles", cnt, TO);
        check1("timeout_bus_err", bus_err, 1'b1);
        check1("timeout_d_ack", d_ack, 1'b1);
        check32("timeout_err_addr", err_addr, 32'h3000);
        check32("timeout_d_rdata", d_rdata, 32'h0);
        tick();
        check1("timeout_err_pulse_end", bus_err, 1'b0);
        check1("timeout_ack_pulse_end", d_ack, 1'b0);

        // Ready arrives on the same edge the wait count would expire.
        d_req = 1'b1; d_addr = 32'h3100;
        tick();
        d_req = 1'b0;
        repeat (TO - 1) tick();
        check1("race_still_granted", bus_req, 1'b1);
        bus_ready = 1'b1; bus_rdata = 32'hBEEF;
        tick();
        bus_ready = 1'b0;
        check1("race_d_ack", d_ack, 1'b1);
        check1("race_bus_err", bus_err, 1'b0);
        check32("race_d_rdata", d_rdata, 32'hBEEF);
        check32("race_err_addr", err_addr, 32'h3000);

        // Asynchronous reset in the middle of a fetch grant.
        do_reset();
        if_req = 1'b1; if_addr = 32'h500;
        tick();
        check1("midrst_granted", bus_req, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check1("midrst_bus_req_async", bus_req, 1'b0);
        check32("midrst_bus_addr_async", bus_addr, 32'h0);
        bus_ready = 1'b1; bus_rdata = 32'h99;
        tick();
        reset = 1'b1;
        if_req = 1'b0; bus_ready = 1'b0;
        tick();
        check1("midrst_no_stale_ack", if_ack, 1'b0);
        check32("midrst_if_rdata", if_rdata, 32'h0);
        tick();
        check1("midrst_no_late_ack", if_ack, 1'b0);
        check1("midrst_idle", bus_req, 1'b0);

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if_req    = ($urandom_range(0, 2) != 0);
            d_req     = ($urandom_range(0, 2) != 0);
            d_we      = ($urandom_range(0, 1) != 0);
            if_addr   = $urandom();
            d_addr    = $urandom();
            d_wdata   = $urandom();
            d_type    = 3'($urandom_range(0, 7));
            bus_ready = ($urandom_range(0, 9) < 4);
            bus_rdata = $urandom();
            m_edge();
            tick();
            check1("rnd_bus_req", bus_req, m_owner != 0);
            if (m_owner != 0) begin
                check1("rnd_bus_we", bus_we, m_we);
                check32("rnd_bus_addr", bus_addr, m_addr);
                check32("rnd_bus_wdata", bus_wdata, m_wdata);
                check32("rnd_bus_type", {29'b0, bus_type}, {29'b0, m_type});
            end
            check1("rnd_if_ack", if_ack, m_if_ack);
            check1("rnd_d_ack", d_ack, m_d_ack);
            check32("rnd_if_rdata", if_rdata, m_if_rdata);
            check32("rnd_d_rdata", d_rdata, m_d_rdata);
            check1("rnd_bus_err", bus_err, m_err);
            check32("rnd_err_addr", err_addr, m_err_addr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
